// File: rtl/regfile_pkg.sv
// regfile_pkg: values shared by the register-file write arbiter and its
// two-way arbiter.
//   DATA_W / ADDR_W      default write-data and register-index widths
//   REQ_A / REQ_B        requester IDs (also the last_grant encoding)
//   PRIO_RR / PRIO_FIXED encodings of the PRIO_MODE parameter
//   wr_state_t           write-port FSM states
package regfile_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic REQ_A = 1'b0;  // ALU writeback
    localparam logic REQ_B = 1'b1;  // memory-load writeback

    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_COMMIT = 1'b1
    } wr_state_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: two-way grant logic with a remembered last owner.
//   clk, rst_n   clock, asynchronous active-low reset
//   req[1:0]     request per requester, bit index = requester ID
//   hold         stall: no grant while high
//   mode         0 = round-robin, 1 = fixed priority to requester A
//   gnt[1:0]     one-hot (or zero) grant, combinational
//   last_grant   owner of the most recent grant (REQ_A / REQ_B)
module rr_arbiter_2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       hold,
    input  logic       mode,
    output logic [1:0] gnt,
    output logic       last_grant
);

    // Grants are suppressed during reset so no handshake can complete
    // while the block is held.
    always_comb begin
        gnt = 2'b00;
        if (rst_n && !hold) begin
            if (req == 2'b11) begin
                // Tie: fixed mode always picks A; round-robin picks
                // whoever did not own the previous transfer.
                if (mode || (last_grant == REQ_B)) begin
                    gnt = 2'b01;
                end else begin
                    gnt = 2'b10;
                end
            end else begin
                gnt = req;
            end
        end
    end

    // Reset to B so that A wins the first round-robin tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= REQ_B;
        end else if (gnt[0]) begin
            last_grant <= REQ_A;
        end else if (gnt[1]) begin
            last_grant <= REQ_B;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: merges two writeback requesters (A = ALU,
// B = memory load) onto the single write port of a register file.
//   clk, rst_n                       clock, asynchronous active-low reset
//   a_valid/a_reg/a_data, a_ready    requester A handshake
//   b_valid/b_reg/b_data, b_ready    requester B handshake
//   hold                             pipeline stall, blocks all grants
//   ld, write_reg, data              registered write port to the regfile
//   last_grant                       owner of most recent transfer (0=A)
//   zero_drop                        pulse: accepted write targeted reg 0
//   wr_count                         committed-write counter (wraps)
//   state_dbg                        current FSM state (1 = COMMIT)
//
// Handshake: a transfer happens on a rising edge where x_valid and x_ready
// are both high. x_ready is combinational from the valids, hold and the
// arbitration state, at most one ready is high per cycle, and a requester
// may drop valid at any time before its grant without side effects.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_W    = regfile_pkg::DATA_W,
    parameter int ADDR_W    = regfile_pkg::ADDR_W,
    parameter int PRIO_MODE = PRIO_RR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_reg,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_reg,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    input  logic              hold,
    output logic              ld,
    output logic [ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0] data,
    output logic              last_grant,
    output logic              zero_drop,
    output logic [15:0]       wr_count,
    output logic              state_dbg
);

    wr_state_t         state;
    wr_state_t         next_state;
    logic [1:0]        gnt;
    logic              xfer;
    logic              wr_hit;
    logic [ADDR_W-1:0] sel_reg;
    logic [DATA_W-1:0] sel_data;

    rr_arbiter_2 u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        ({b_valid, a_valid}),
        .hold       (hold),
        .mode       (PRIO_MODE == PRIO_FIXED),
        .gnt        (gnt),
        .last_grant (last_grant)
    );

    assign a_ready  = gnt[0];
    assign b_ready  = gnt[1];
    assign xfer     = |gnt;
    assign sel_reg  = gnt[1] ? b_reg  : a_reg;
    assign sel_data = gnt[1] ? b_data : a_data;
    // Register 0 is hardwired: the handshake completes but nothing commits.
    assign wr_hit   = xfer && (sel_reg != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // COMMIT lasts exactly one cycle per accepted write; back-to-back
    // nonzero transfers keep the FSM in COMMIT.
    always_comb begin
        next_state = ST_IDLE;
        if (wr_hit) begin
            next_state = ST_COMMIT;
        end
    end

    always_comb begin
        ld        = (state == ST_COMMIT);
        state_dbg = (state == ST_COMMIT);
    end

    // Write port payload only changes on a committing transfer, so it holds
    // its last value while idle. wr_count steps on entry to COMMIT, making
    // it already include the write currently presented with ld=1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_reg <= '0;
            data      <= '0;
            zero_drop <= 1'b0;
            wr_count  <= 16'h0000;
        end else begin
            zero_drop <= xfer && !wr_hit;
            if (wr_hit) begin
                write_reg <= sel_reg;
                data      <= sel_data;
                wr_count  <= wr_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // shared stimulus
  logic          a_valid = 1'b0, b_valid = 1'b0, hold = 1'b0;
  logic [AW-1:0] a_reg = '0, b_reg = '0;
  logic [DW-1:0] a_data = '0, b_data = '0;

  // per-instance observations: index 0 = round-robin, 1 = fixed priority
  logic [1:0]    a_rdy, b_rdy, ld_o, lg_o, zd_o, st_o;
  logic [AW-1:0] wreg_o [2];
  logic [DW-1:0] wdat_o [2];
  logic [15:0]   cnt_o  [2];

  regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .PRIO_MODE(0)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_rdy[0]),
    .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_rdy[0]),
    .hold(hold), .ld(ld_o[0]), .write_reg(wreg_o[0]), .data(wdat_o[0]),
    .last_grant(lg_o[0]), .zero_drop(zd_o[0]), .wr_count(cnt_o[0]),
    .state_dbg(st_o[0])
  );

  regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .PRIO_MODE(1)) u_fx (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_rdy[1]),
    .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_rdy[1]),
    .hold(hold), .ld(ld_o[1]), .write_reg(wreg_o[1]), .data(wdat_o[1]),
    .last_grant(lg_o[1]), .zero_drop(zd_o[1]), .wr_count(cnt_o[1]),
    .state_dbg(st_o[1])
  );

  // scoreboard / reference model
  int n_checks = 0;
  int n_errors = 0;

  int            m_last [2];
  logic          m_ld   [2];
  logic          m_zero [2];
  logic [AW-1:0] m_reg  [2];
  logic [DW-1:0] m_data [2];
  int            m_cnt  [2];
  logic [DW-1:0] exp_rf [2][32];
  logic [DW-1:0] dut_rf [2][32];
  logic [DW-1:0] exp_q [$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Who should win this cycle: -1 none, 0 A, 1 B.
  function automatic int winner(input int k);
    if (!rst_n || hold) return -1;
    if (a_valid && b_valid) begin
      if (k == 1) return 0;
      return (m_last[k] == 1) ? 0 : 1;
    end
    if (a_valid) return 0;
    if (b_valid) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_last[k] = 1;
      m_ld[k]   = 1'b0;
      m_zero[k] = 1'b0;
      m_reg[k]  = '0;
      m_data[k] = '0;
      m_cnt[k]  = 0;
    end
  endtask

  // One clock: inputs were applied at the preceding negedge.
  task automatic step();
    int g;
    logic [AW-1:0] r;
    logic [DW-1:0] d;
    #1;
    for (int k = 0; k < 2; k++) begin
      // the regfile captures the presented write at the coming edge
      if (ld_o[k]) dut_rf[k][wreg_o[k]] = wdat_o[k];
      if (m_ld[k]) exp_rf[k][m_reg[k]] = m_data[k];
      g = winner(k);
      check_val("a_ready", {31'd0, a_rdy[k]}, {31'd0, g == 0});
      check_val("b_ready", {31'd0, b_rdy[k]}, {31'd0, g == 1});
      m_ld[k]   = 1'b0;
      m_zero[k] = 1'b0;
      if (g >= 0) begin
        m_last[k] = g;
        r = (g == 1) ? b_reg : a_reg;
        d = (g == 1) ? b_data : a_data;
        if (r != 0) begin
          m_ld[k]   = 1'b1;
          m_reg[k]  = r;
          m_data[k] = d;
          m_cnt[k]  = (m_cnt[k] + 1) % 65536;
        end else begin
          m_zero[k] = 1'b1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check_val("ld", {31'd0, ld_o[k]}, {31'd0, m_ld[k]});
      check_val("state_dbg", {31'd0, st_o[k]}, {31'd0, m_ld[k]});
      check_val("write_reg", {27'd0, wreg_o[k]}, {27'd0, m_reg[k]});
      check_val("data", wdat_o[k], m_data[k]);
      check_val("zero_drop", {31'd0, zd_o[k]}, {31'd0, m_zero[k]});
      check_val("wr_count", {16'd0, cnt_o[k]}, m_cnt[k]);
      check_val("last_grant", {31'd0, lg_o[k]}, m_last[k]);
    end
  endtask

  // Called at a negedge; asserts reset immediately, checks forced values.
  task automatic do_reset();
    rst_n = 1'b0;
    a_valid = 1'b1;
    b_valid = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      check_val("rst_ld", {31'd0, ld_o[k]}, 0);
      check_val("rst_write_reg", {27'd0, wreg_o[k]}, 0);
      check_val("rst_data", wdat_o[k], 0);
      check_val("rst_last_grant", {31'd0, lg_o[k]}, 1);
      check_val("rst_zero_drop", {31'd0, zd_o[k]}, 0);
      check_val("rst_wr_count", {16'd0, cnt_o[k]}, 0);
      check_val("rst_a_ready", {31'd0, a_rdy[k]}, 0);
      check_val("rst_b_ready", {31'd0, b_rdy[k]}, 0);
    end
    model_reset();
    a_valid = 1'b0;
    b_valid = 1'b0;
    hold = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 32; i++) begin
        exp_rf[k][i] = '0;
        dut_rf[k][i] = '0;
      end
    model_reset();
    @(negedge clk);
    do_reset();

    // single A write
    a_valid = 1'b1; a_reg = 5'd5; a_data = 32'h0000_00AA;
    step();
    a_valid = 1'b0;
    check_val("single_ld", {31'd0, ld_o[0]}, 1);
    check_val("single_reg", {27'd0, wreg_o[0]}, 5);
    check_val("single_data", wdat_o[0], 32'hAA);
    check_val("single_cnt", {16'd0, cnt_o[0]}, 1);
    step();
    check_val("idle_hold_reg", {27'd0, wreg_o[0]}, 5);

    // round-robin contention after reset
    do_reset();
    a_valid = 1'b1; a_reg = 5'd3; a_data = 32'h11;
    b_valid = 1'b1; b_reg = 5'd4; b_data = 32'h22;
    #1;
    check_val("rr_c1_a", {31'd0, a_rdy[0]}, 1);
    step();
    check_val("rr_c1_ld", {31'd0, ld_o[0]}, 1);
    check_val("rr_c1_reg", {27'd0, wreg_o[0]}, 3);
    #1;
    check_val("rr_c2_b", {31'd0, b_rdy[0]}, 1);
    step();
    check_val("rr_c2_ld", {31'd0, ld_o[0]}, 1);
    check_val("rr_c2_reg", {27'd0, wreg_o[0]}, 4);
    check_val("rr_c2_last", {31'd0, lg_o[0]}, 1);

    // fixed priority: A wins every tie, changing its index each cycle
    for (int i = 0; i < 3; i++) begin
      a_reg = 5'(10 + i); a_data = $urandom;
      #1;
      check_val("fx_a_ready", {31'd0, a_rdy[1]}, 1);
      check_val("fx_b_ready", {31'd0, b_rdy[1]}, 0);
      step();
      check_val("fx_reg", {27'd0, wreg_o[1]}, 10 + i);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    step();

    // register 0 write from B
    b_valid = 1'b1; b_reg = 5'd0; b_data = 32'hDEAD;
    exp_q.push_back({16'd0, cnt_o[0]});
    step();
    b_valid = 1'b0;
    check_val("z_ld", {31'd0, ld_o[0]}, 0);
    check_val("z_drop", {31'd0, zd_o[0]}, 1);
    check_val("z_cnt", {16'd0, cnt_o[0]}, exp_q.pop_front());
    step();

    // hold blocks both requesters
    hold = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
    a_reg = 5'd1; b_reg = 5'd2;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_val("hold_ready", {30'd0, a_rdy | b_rdy}, 0);
      step();
    end
    hold = 1'b0; b_valid = 1'b0;
    a_reg = 5'd9; a_data = 32'h55;
    step();
    check_val("abort_ld_pre", {31'd0, ld_o[0]}, 1);
    a_valid = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) step();
    check_val("abort_rf9", dut_rf[0][9], 0);

    // same index ordering: A then B to reg 7
    a_valid = 1'b1; a_reg = 5'd7; a_data = 32'h1;
    b_valid = 1'b1; b_reg = 5'd7; b_data = 32'h2;
    step();
    a_valid = 1'b0;
    step();
    b_valid = 1'b0;
    step();
    check_val("rf7_rr", dut_rf[0][7], 32'h2);
    check_val("rf7_fx", dut_rf[1][7], 32'h2);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      a_valid = 1'($urandom_range(0, 1));
      b_valid = 1'($urandom_range(0, 1));
      hold    = ($urandom_range(0, 7) == 0);
      a_reg   = 5'($urandom_range(0, 7));
      b_reg   = 5'($urandom_range(0, 7));
      a_data  = $urandom;
      b_data  = $urandom;
      step();
    end
    a_valid = 1'b0; b_valid = 1'b0; hold = 1'b0;
    step();
    step();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 32; i++)
        check_val("rf_final", dut_rf[k][i], exp_rf[k][i]);

    // counter wrap
    @(negedge clk);
    do_reset();
    a_valid = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      a_reg  = 5'($urandom_range(1, 31));
      a_data = $urandom;
      step();
    end
    check_val("wrap_pre", {16'd0, cnt_o[0]}, 32'hFFFF);
    step();
    check_val("wrap_post", {16'd0, cnt_o[0]}, 0);
    a_valid = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter DATA_W, default 32: width of write data.
REQ-002 Parameter ADDR_W, default 5: width of register index.
REQ-003 Parameter PRIO_MODE, default 0: 0 = round-robin, 1 = fixed priority to requester A.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 Clk  input  1  rising-edge clock, shared with the register file.
REQ-006 Rst_n  input  1  asynchronous active-low reset.
REQ-007 a_valid  input  1  requester A (ALU writeback) has a write pending.
REQ-008 a_reg / a_data  input  ADDR_W / DATA_W  requester A destination index and data.
REQ-009 a_ready  output  1  requester A transfer accepted this cycle.
REQ-010 b_valid, b_reg, b_data, b_ready: same as REQ-007..009, for requester B (memory-load writeback).
REQ-011 hold  input  1  pipeline stall; blocks all grants.
REQ-012 Ld  output  1  write enable to the register file decoder.
REQ-013 write_reg  output  ADDR_W  register index to the register file.
REQ-014 data  output  DATA_W  write data to the register file.
REQ-015 last_grant  output  1  0 = A, 1 = B; owner of the most recent transfer.
REQ-016 zero_drop  output  1  one-cycle pulse: an accepted write targeted register 0.
REQ-017 wr_count  output  16  count of committed writes (Ld=1 cycles).

Function
REQ-018 A transfer SHALL occur on a rising edge when x_valid=1 and x_ready=1.
REQ-019 x_ready SHALL be combinational from the valids, hold and the arbitration state; at most one ready is high per cycle.
REQ-020 When hold=1, both ready outputs SHALL be 0.
REQ-021 With one valid and hold=0, that requester SHALL be ready in the same cycle.
REQ-022 Round-robin mode: with both valid, grant goes to the requester not equal to last_grant; last_grant updates only on a transfer.
REQ-023 Fixed mode: with both valid, A SHALL always be granted.
REQ-024 The FSM has two states: IDLE (Ld=0) and COMMIT (Ld=1). A transfer of a nonzero index enters COMMIT on the next cycle. COMMIT returns to IDLE unless another nonzero transfer occurs in the same cycle (back-to-back).
REQ-025 Latency: write_reg, data and Ld SHALL be registered and appear one cycle after the transfer edge. The register file captures on the following edge, so throughput is one write per cycle.
REQ-026 A transfer with index 0 SHALL complete the handshake but SHALL NOT assert Ld. In the next cycle it pulses zero_drop and leaves wr_count unchanged.
REQ-027 Both requesters valid to the same index: writes SHALL commit in grant order, and the later write wins.
REQ-028 write_reg and data SHALL hold their last values while in IDLE.
REQ-029 wr_count SHALL increment by 1 per COMMIT cycle and wrap from 0xFFFF to 0x0000.
REQ-030 If a requester drops valid before its grant, no write is issued for it.

Reset
REQ-031 When Rst_n=0, all of the following SHALL be forced immediately, independent of Clk: state IDLE, Ld=0, write_reg=0, data=0, last_grant=1 (so A wins first round-robin tie), zero_drop=0, wr_count=0.
REQ-032 a_ready and b_ready SHALL be 0 while Rst_n=0.
REQ-033 Reset asserted during COMMIT SHALL abort the pending write; no Ld is issued after reset releases.
REQ-034 The block leaves reset on the first rising edge of Clk after Rst_n rises.

Structure
REQ-035 The shared package regfile_pkg SHALL hold DATA_W, ADDR_W, the requester IDs REQ_A=0 / REQ_B=1, and the PRIO_MODE encodings.
REQ-036 Two-way arbitration SHALL be a sub-module rr_arbiter_2 (inputs req[1:0], hold, mode; outputs gnt[1:0], last_grant register).
REQ-037 Outputs connect directly to the register file's data, write_reg, Ld and Clk ports; there is no other glue.

Verification
REQ-038 Reset then a single A write: a_valid=1, a_reg=5, a_data=0x0000_00AA for one cycle -> a_ready=1 same cycle; next cycle Ld=1, write_reg=5, data=0xAA; wr_count=1.
REQ-039 Round-robin contention: A (reg 3, 0x11) and B (reg 4, 0x22) held valid after reset -> A granted cycle 1, B cycle 2; Ld high two consecutive cycles; last_grant=1.
REQ-040 PRIO_MODE=1 with both valid for 3 cycles, A changing its index each cycle -> A granted all 3 cycles; b_ready=0 throughout.
REQ-041 Register-0 write: B valid, b_reg=0, b_data=0xDEAD -> b_ready=1; next cycle Ld=0, zero_drop=1; wr_count unchanged.
REQ-042 Hold and reset: hold=1 with both valid -> no ready for 4 cycles. Then release hold, and assert Rst_n=0 mid-COMMIT -> Ld drops immediately to 0; after release, no write to the aborted index occurs.
REQ-043 Same-index ordering and wrap: A then B both to reg 7 (0x1, 0x2) -> reading reg 7 returns 0x2. Preload wr_count to 0xFFFF -> one commit gives 0x0000.
